// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass, per-register busy scoreboard
// and a sequential clear engine. Optional stored parity via REGFILE_PARITY_EN.
//
// state | meaning
// IDLE  | normal operation: writes, allocs and bypass active
// CLEAR | zeroing entry idx (value, busy and parity) once per cycle
// DONE  | clear complete, clr_done high for this cycle only
module regfile_mp_sb #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int NUM_RD_PORTS  = 2,
    parameter int ZERO_REG      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD_PORTS-1:0]               rd_busy,
    input  logic                                  wr_en,
    input  logic [ADDRESS_WIDTH-1:0]              wr_dest,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic                                  alloc_en,
    input  logic [ADDRESS_WIDTH-1:0]              alloc_dest,
    input  logic                                  clr_req,
    output logic                                  clr_busy,
    output logic                                  clr_done,
    output logic [NUM_RD_PORTS-1:0]               rd_perr,
    input  logic                                  wr_perr_inj
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int IW = $clog2(NUM_REGS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [DW-1:0]       regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [1:0]          state;
    logic [IW-1:0]       idx;
    logic                wr_ok;
    logic                al_ok;

`ifdef REGFILE_PARITY_EN
    logic [NUM_REGS-1:0] par;
`else
    logic unused_perr_inj;
    assign unused_perr_inj = wr_perr_inj;
`endif

    // In range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok    = (state == ST_IDLE) && wr_en && addr_ok(wr_dest);
    assign al_ok    = (state == ST_IDLE) && alloc_en && addr_ok(alloc_dest);
    assign clr_busy = (state != ST_IDLE);
    assign clr_done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            busy  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef REGFILE_PARITY_EN
            par   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        idx   <= '0;
                    end
                    if (wr_ok) begin
                        regs[wr_dest] <= wr_data;
                        busy[wr_dest] <= 1'b0;
`ifdef REGFILE_PARITY_EN
                        par[wr_dest]  <= (^wr_data) ^ wr_perr_inj;
`endif
                    end
                    // Placed after the write so a same-edge alloc wins.
                    if (al_ok) busy[alloc_dest] <= 1'b1;
                end
                ST_CLEAR: begin
                    regs[idx] <= '0;
                    busy[idx] <= 1'b0;
`ifdef REGFILE_PARITY_EN
                    par[idx]  <= 1'b0;
`endif
                    if (idx == IW'(NUM_REGS - 1)) state <= ST_DONE;
                    else                          idx   <= idx + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] a;
        logic          ok;
        logic          hit;
        assign a   = rd_addr[p*AW +: AW];
        assign ok  = addr_ok(a);
        assign hit = ok && wr_ok && (wr_dest == a);
        assign rd_data[p*DW +: DW] = !ok ? '0 : (hit ? wr_data : regs[a]);
        assign rd_busy[p]          = ok && !hit && busy[a];
`ifdef REGFILE_PARITY_EN
        assign rd_perr[p] = ok && !hit && ((^regs[a]) != par[a]);
`else
        assign rd_perr[p] = 1'b0;
`endif
    end

endmodule
